// File: rtl/mem_responder.sv
// Memory-side responder for the cache fill/write-through port: writes are committed on
// acceptance, and reads return through a fixed-latency pipeline with the request address echoed.
module mem_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [3:0]        pending
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [15:0]                    mem_q [MEM_WORDS];
  logic [LATENCY-1:0]             valid_q, valid_d;
  logic [LATENCY-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [LATENCY-1:0][15:0]       data_q, data_d;
  logic [3:0]                     pending_q, pending_d;

  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] word_addr;
  logic              issue;
  logic              do_write;
  logic              retire;
  logic              unused_addr_lsb;

  // Byte address bit 0 selects nothing in 16-bit storage.
  assign unused_addr_lsb = addr[0];
  assign word_addr       = {addr[ADDR_W-1:1], 1'b0};
  assign word_idx        = IDX_W'(32'(addr[ADDR_W-1:1]) % MEM_WORDS);

  // A request presented while rst is high is dropped entirely.
  assign issue    = enable && !wr && !rst;
  assign do_write = enable &&  wr && !rst;
  assign retire   = valid_q[LATENCY-1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    valid_d[0] = issue;
    if (issue) begin
      addr_d[0] = word_addr;
      data_d[0] = mem_q[word_idx];
    end
    // Payload only moves with a valid entry, so the last stage holds the last returned read.
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        addr_d[i] = addr_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
    pending_d = pending_q + 4'(issue) - 4'(retire);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  // NOTE: storage has no reset; contents survive rst and are preloaded externally.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[word_idx] <= data_in;
    end
  end

  assign data_valid = valid_q[LATENCY-1];
  assign data_out   = data_q[LATENCY-1];
  assign addr_out   = addr_q[LATENCY-1];
  assign pending    = pending_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (default sizing, and a 16-word latency-1
// variant) share stimulus; a queue-based reference model predicts data, address and return cycle.
module tb_mem_responder;

  localparam int LAT0   = 4;
  localparam int WORDS0 = 32768;
  localparam int LAT1   = 1;
  localparam int WORDS1 = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;

  logic        dv   [2];
  logic [15:0] dout [2];
  logic [15:0] aout [2];
  logic [3:0]  pend [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    int          inst;
    int          c;
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem0 [WORDS0];
  logic [15:0] mem1 [WORDS1];
  logic [15:0] last_data [2];
  logic [15:0] last_addr [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.LATENCY(LAT0), .ADDR_W(16), .MEM_WORDS(WORDS0)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[0]), .data_valid(dv[0]), .addr_out(aout[0]), .pending(pend[0])
  );

  mem_responder #(.LATENCY(LAT1), .ADDR_W(16), .MEM_WORDS(WORDS1)) u_wrap (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(dout[1]), .data_valid(dv[1]), .addr_out(aout[1]), .pending(pend[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One request per cycle; the model applies it in acceptance order.
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
    int i0;
    int i1;
    @(posedge clk);
    #1;
    rst = r; enable = e; wr = w; addr = a; data_in = d;
    i0 = int'(a[15:1]) % WORDS0;
    i1 = int'(a[15:1]) % WORDS1;
    if (!r && e) begin
      if (w) begin
        mem0[i0] = d;
        mem1[i1] = d;
      end else begin
        sb.push_back('{0, cyc, cyc + LAT0, {a[15:1], 1'b0}, mem0[i0]});
        sb.push_back('{1, cyc, cyc + LAT1, {a[15:1], 1'b0}, mem1[i1]});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  always @(negedge clk) begin
    int idx;
    int n;
    if (mon_on) begin
      for (int i = 0; i < 2; i++) begin
        idx = -1;
        n   = 0;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].inst == i) begin
            if (idx < 0) idx = j;
            if (sb[j].c < cyc) n++;
          end
        end
        check($sformatf("pending[%0d]", i), 32'(pend[i]), n);
        if (dv[i] === 1'b1) begin
          if (idx < 0) begin
            check($sformatf("spurious_valid[%0d]", i), 32'(dv[i]), 0);
          end else begin
            check($sformatf("data[%0d]", i), 32'(dout[i]), 32'(sb[idx].data));
            check($sformatf("addr[%0d]", i), 32'(aout[i]), 32'(sb[idx].addr));
            check($sformatf("return_cycle[%0d]", i), cyc, sb[idx].due);
            last_data[i] = sb[idx].data;
            last_addr[i] = sb[idx].addr;
            sb.delete(idx);
          end
        end else begin
          check($sformatf("hold_data[%0d]", i), 32'(dout[i]), 32'(last_data[i]));
          check($sformatf("hold_addr[%0d]", i), 32'(aout[i]), 32'(last_addr[i]));
          if (idx >= 0 && sb[idx].due <= cyc) begin
            check($sformatf("missing_valid[%0d]", i), 32'(dv[i]), 1);
            sb.delete(idx);
          end
        end
      end
      // The reset edge that follows discards in-flight reads and clears the output registers.
      if (rst === 1'b1) begin
        sb.delete();
        for (int i = 0; i < 2; i++) begin
          last_data[i] = '0;
          last_addr[i] = '0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 2; i++) begin
      last_data[i] = '0;
      last_addr[i] = '0;
    end
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_valid[%0d]", i), 32'(dv[i]), 0);
      check($sformatf("reset_data[%0d]", i), 32'(dout[i]), 0);
      check($sformatf("reset_addr[%0d]", i), 32'(aout[i]), 0);
      check($sformatf("reset_pending[%0d]", i), 32'(pend[i]), 0);
    end
    mon_on = 1'b1;

    // Preload words 0..63 through the write port.
    for (int w = 0; w < 64; w++) step(1'b0, 1'b1, 1'b1, 16'(w * 2), 16'($urandom));
    idle(2);

    // Single read.
    step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    idle(6);

    // Block fill, back-to-back.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b0, 16'(16'h0020 + 2 * k), 16'h0000);
    idle(6);

    // Write then read.
    step(1'b0, 1'b1, 1'b1, 16'h0040, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    idle(6);

    // Read then write: the in-flight read keeps the old value.
    step(1'b0, 1'b1, 1'b1, 16'h0040, 16'hAAAA);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h0040, 16'h5555);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    idle(6);

    // Reset mid-flight with a write presented in the reset cycle.
    step(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0062, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0064, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0050, 16'hDEAD);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0000);
    idle(6);

    // Odd address and wrap (word 16 aliases index 0 in the 16-word instance).
    step(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    idle(6);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 800; k++) begin
      step(($urandom % 100) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
           16'($urandom % 128), 16'($urandom));
    end

    idle(LAT0 + 3);
    check("drain_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
